// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and widths for the adder-sharing arbiter.
// Build option ADDER_ARB_LOCK_EN (see adder_share_arbiter.sv) does not change this package.
package adder_share_arbiter_pkg;

    localparam int unsigned ADD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Registered operand payload handed to the shared adder
    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
    } add_op_t;

    // Registered result payload returned to the consumer
    typedef struct packed {
        logic             cout;
        logic [ADD_W-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between client units and the adder-sharing arbiter.
// ADDER_ARB_LOCK_EN adds the per-requester req_lock bit.
interface adder_share_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW   = $clog2(NREQ);
    localparam int unsigned ADD_W = adder_share_arbiter_pkg::ADD_W;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
`ifdef ADDER_ARB_LOCK_EN
    logic [NREQ-1:0]       req_lock;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [ADD_W-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    modport master (
`ifdef ADDER_ARB_LOCK_EN
        output req_lock,
`endif
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
`ifdef ADDER_ARB_LOCK_EN
        input  req_lock,
`endif
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/adder_share_arbiter_adder.sv
// 32-bit ripple-carry adder shared by all requesters.
module ThirtyTwoBitAdder
    import adder_share_arbiter_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    logic [ADD_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < ADD_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[ADD_W];
    end

endmodule

// File: rtl/adder_share_arbiter_rr.sv
// Combinational round-robin grant: search starts after rr_ptr and wraps.
// With ADDER_ARB_LOCK_EN, a held lock restricts the grant to requester rr_ptr.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
`ifdef ADDER_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [NREQ-1:0] gnt_oh,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [NREQ-1:0] scan_oh;
    logic [IDW-1:0]  scan_idx;
    logic            scan_any;
    int unsigned     idx;

    // First valid requester after rr_ptr, modulo NREQ
    always_comb begin
        scan_oh  = '0;
        scan_idx = '0;
        scan_any = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!scan_any && req_valid[IDW'(idx)]) begin
                scan_oh[IDW'(idx)] = 1'b1;
                scan_idx           = IDW'(idx);
                scan_any           = 1'b1;
            end
        end
    end

`ifdef ADDER_ARB_LOCK_EN
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = rr_ptr;
        gnt_any = 1'b0;
        if (lock) begin
            if (req_valid[rr_ptr]) begin
                gnt_oh[rr_ptr] = 1'b1;
                gnt_any        = 1'b1;
            end
        end else begin
            gnt_oh  = scan_oh;
            gnt_idx = scan_idx;
            gnt_any = scan_any;
        end
    end
`else
    assign gnt_oh  = scan_oh;
    assign gnt_idx = scan_idx;
    assign gnt_any = scan_any;
`endif

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one ThirtyTwoBitAdder among NREQ requesters (IDLE -> EXEC -> RESP).
// Define ADDER_ARB_LOCK_EN for locked multi-word carry chaining via req_lock.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    add_op_t          op_q, op_d;
    logic [IDW-1:0]   op_id_q, op_id_d;
    add_res_t         rsp_q, rsp_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
`ifdef ADDER_ARB_LOCK_EN
    logic             lock_q, lock_d;
`endif

    logic [NREQ-1:0]  gnt_oh;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic [ADD_W-1:0] a_arr [NREQ];
    logic [ADD_W-1:0] b_arr [NREQ];
    logic [ADD_W-1:0] add_sum;
    logic             add_cout;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            a_arr[i] = bus.req_a[ADD_W*i +: ADD_W];
            b_arr[i] = bus.req_b[ADD_W*i +: ADD_W];
        end
    end

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_q),
`ifdef ADDER_ARB_LOCK_EN
        .lock      (lock_q),
`endif
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    ThirtyTwoBitAdder u_add (
        .a    (op_q.a),
        .b    (op_q.b),
        .cin  (op_q.cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Grant is only offered while idle and out of reset
    assign bus.req_ready = (state_q == IDLE && !rst) ? gnt_oh : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_q.sum;
    assign bus.rsp_cout  = rsp_q.cout;
    assign bus.busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        op_id_d     = op_id_q;
        rsp_d       = rsp_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
`ifdef ADDER_ARB_LOCK_EN
        lock_d      = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    op_d.a   = a_arr[gnt_idx];
                    op_d.b   = b_arr[gnt_idx];
`ifdef ADDER_ARB_LOCK_EN
                    // Chained words take the carry of the previous word
                    op_d.cin = lock_q ? rsp_q.cout : bus.req_cin[gnt_idx];
                    lock_d   = bus.req_lock[gnt_idx];
`else
                    op_d.cin = bus.req_cin[gnt_idx];
`endif
                    op_id_d  = gnt_idx;
                    rr_ptr_d = gnt_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_d.sum   = add_sum;
                rsp_d.cout  = add_cout;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            op_q        <= '0;
            op_id_q     <= '0;
            rsp_q       <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADDER_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            op_id_q     <= op_id_d;
            rsp_q       <= rsp_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef ADDER_ARB_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed scoreboard bench for adder_share_arbiter (NREQ=4); lock test runs when ADDER_ARB_LOCK_EN is defined.
module tb_adder_share_arbiter;
    import adder_share_arbiter_pkg::*;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam int          MAXOPS = 8;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        lock;
    } op_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        logic           cout;
        int             acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(NREQ)) bus ();
    adder_share_arbiter #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    op_t  ops [NREQ][MAXOPS];
    int   head [NREQ];
    int   tail [NREQ];
    exp_t exp_q [$];
    int   gnt_log [$];
    int   rise_log [$];
    int   n_cmp = 0;
    int   n_mism = 0;
    int   n_rsp = 0;
    int   cyc = 0;
    logic prev_rv = 1'b0;
    logic m_lock = 1'b0;
    logic m_cout = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (head[i] < tail[i]) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_a[32*i +: 32]  = ops[i][head[i]].a;
                bus.req_b[32*i +: 32]  = ops[i][head[i]].b;
                bus.req_cin[i]         = ops[i][head[i]].cin;
`ifdef ADDER_ARB_LOCK_EN
                bus.req_lock[i]        = ops[i][head[i]].lock;
`endif
            end else begin
                bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic add_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic lock);
        ops[i][tail[i]] = {a, b, cin, lock};
        tail[i]++;
        drive();
    endtask

    // Observe handshakes in the low phase, then advance one clock
    task automatic cycle();
        op_t             op;
        logic            cin_eff;
        logic [32:0]     res;
        exp_t            e;
        logic [NREQ-1:0] acc;
        acc = '0;
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                op      = ops[i][head[i]];
                cin_eff = op.cin;
`ifdef ADDER_ARB_LOCK_EN
                if (m_lock) cin_eff = m_cout;
                m_lock = op.lock;
`endif
                res       = 33'(op.a) + 33'(op.b) + 33'(cin_eff);
                m_cout    = res[32];
                e.id      = IDW'(i);
                e.sum     = res[31:0];
                e.cout    = res[32];
                e.acc_cyc = cyc;
                exp_q.push_back(e);
                gnt_log.push_back(i);
                acc[i] = 1'b1;
            end
        end
        if (bus.rsp_valid && !prev_rv) begin
            rise_log.push_back(cyc);
            if (exp_q.size() > 0) check("latency", 64'(cyc), 64'(exp_q[0].acc_cyc + 2));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
                check("rsp_sum",  64'(bus.rsp_sum),  64'(e.sum));
                check("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
            end
            n_rsp++;
        end
        prev_rv = bus.rsp_valid;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) if (acc[i]) head[i]++;
        drive();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int b;
        b = budget;
        while (n_rsp < target && b > 0) begin
            cycle();
            b--;
        end
        check(tag, 64'(n_rsp), 64'(target));
    endtask

    task automatic flush_model();
        exp_q.delete();
        m_lock  = 1'b0;
        m_cout  = 1'b0;
        prev_rv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush_model();
        @(negedge clk);
        rst = 1'b0;
        drive();
    endtask

    initial begin
        int   base;
        int   b;
        int   exp_ord3 [5];
        exp_ord3 = '{0, 1, 2, 3, 0};

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
`ifdef ADDER_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
        check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        check("rst_rsp_cout",  64'(bus.rsp_cout),  64'd0);
        rst = 1'b0;
        drive();

        // Single request from requester 0
        add_op(0, 32'd1, 32'd0, 1'b0, 1'b0);
        #1 check("t1_req_ready", 64'(bus.req_ready), 64'b0001);
        cycle();
        #1 check("t1_busy_exec", 64'(bus.busy), 64'd1);
        check("t1_ready_exec", 64'(bus.req_ready), 64'd0);
        run_until(1, 10, "t1_done");

        // Overflow wrap with carry-out
        add_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_until(n_rsp + 1, 10, "t2_done");

        // All four valid from reset: rotation and throughput
        do_reset();
        gnt_log.delete();
        rise_log.delete();
        add_op(0, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        add_op(0, $urandom, $urandom, 1'b1, 1'b0);
        add_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        add_op(2, $urandom, $urandom, 1'b0, 1'b0);
        add_op(3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        base = n_rsp;
        run_until(base + 5, 40, "t3_done");
        check("t3_gnt_count", 64'(gnt_log.size()), 64'd5);
        for (int k = 0; k < 5; k++)
            if (k < gnt_log.size()) check("t3_gnt_order", 64'(gnt_log[k]), 64'(exp_ord3[k]));
        check("t3_rise_count", 64'(rise_log.size()), 64'd5);
        for (int k = 1; k < 5; k++)
            if (k < rise_log.size()) check("t3_interval", 64'(rise_log[k] - rise_log[k-1]), 64'd3);

        // Response stall with another request pending
        bus.rsp_ready = 1'b0;
        add_op(2, 32'hDEAD_BEEF, 32'h1000_0001, 1'b1, 1'b0);
        add_op(3, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
        b = 20;
        while (!bus.rsp_valid && b > 0) begin
            cycle();
            b--;
        end
        check("t4_reach", 64'(bus.rsp_valid), 64'd1);
        for (int s = 0; s < 5; s++) begin
            cycle();
            #1;
            check("t4_valid", 64'(bus.rsp_valid), 64'd1);
            check("t4_ready", 64'(bus.req_ready), 64'd0);
            if (exp_q.size() > 0) begin
                check("t4_sum", 64'(bus.rsp_sum), 64'(exp_q[0].sum));
                check("t4_id",  64'(bus.rsp_id),  64'(exp_q[0].id));
            end
        end
        bus.rsp_ready = 1'b1;
        run_until(n_rsp + 2, 20, "t4_done");

        // Reset while the operation is in EXEC
        add_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        cycle();
        rst = 1'b1;
        #1;
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t5_busy",      64'(bus.busy),      64'd0);
        flush_model();
        add_op(2, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        add_op(0, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0);
        #1 check("t5_ready_in_rst", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("t5_first_grant", 64'(bus.req_ready), 64'b0001);
        run_until(n_rsp + 2, 20, "t5_done");

`ifdef ADDER_ARB_LOCK_EN
        // Two-word chained add on requester 2 with requester 1 competing
        do_reset();
        gnt_log.delete();
        add_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        cycle();
        add_op(1, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
        run_until(n_rsp + 1, 10, "t6_word0");
        for (int s = 0; s < 3; s++) begin
            cycle();
            #1;
            check("t6_lock_hold", 64'(bus.req_ready), 64'd0);
            check("t6_idle_wait", 64'(bus.busy),      64'd0);
        end
        add_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
        #1 check("t6_word1_grant", 64'(bus.req_ready), 64'b0100);
        run_until(n_rsp + 2, 20, "t6_done");
        check("t6_gnt_count", 64'(gnt_log.size()), 64'd3);
        if (gnt_log.size() == 3) begin
            check("t6_gnt0", 64'(gnt_log[0]), 64'd2);
            check("t6_gnt1", 64'(gnt_log[1]), 64'd2);
            check("t6_gnt2", 64'(gnt_log[2]), 64'd1);
        end
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
